mul4_shift_add: RTL and testbench



---
 rtl/mul4_pkg.sv | 15 +
 rtl/Sum_instancia4b.sv | 23 ++
 rtl/mul4_shift_add.sv | 85 ++++++++
 tb/tb_mul4_shift_add.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mul4_pkg.sv
// Shared constants and state encoding for the 4x4 shift-and-add multiplier.
package mul4_pkg;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned ITER  = 4;
  localparam int unsigned PW    = 8;
  localparam int unsigned CW    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/Sum_instancia4b.sv
// 4-bit ripple-carry adder used as the per-iteration adder of the multiplier.
module Sum_instancia4b (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cn,
  output logic [3:0] S,
  output logic       Co
);

  logic carry;

  // Bit-serial full-adder chain, LSB first.
  always_comb begin
    carry = Cn;
    S     = 4'h0;
    for (int i = 0; i < 4; i++) begin
      S[i]  = A[i] ^ B[i] ^ carry;
      carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
    end
    Co = carry;
  end

endmodule

// File: rtl/mul4_shift_add.sv
// Sequential 4x4 unsigned multiplier: one add/shift per clock around the
// ripple-carry adder, with a start/busy/done handshake.
module mul4_shift_add
  import mul4_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [PW-1:0]    p
);

  state_t           state;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] acc_hi;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] add_b_c;
  logic [WIDTH-1:0] sum_c;
  logic             co_c;

  assign add_b_c = q[0] ? m : '0;

  Sum_instancia4b u_add (
    .A  (acc_hi),
    .B  (add_b_c),
    .Cn (1'b0),
    .S  (sum_c),
    .Co (co_c)
  );

  // Control FSM and datapath; carry-out shifts into acc_hi[3] so nothing is lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      p      <= '0;
      m      <= '0;
      q      <= '0;
      acc_hi <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            m      <= a;
            q      <= b;
            acc_hi <= '0;
            cnt    <= '0;
            state  <= CALC;
            busy   <= 1'b1;
          end
        end
        CALC: begin
          acc_hi <= {co_c, sum_c[WIDTH-1:1]};
          q      <= {sum_c[0], q[WIDTH-1:1]};
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(ITER - 1)) begin
            p     <= {co_c, sum_c, q[WIDTH-1:1]};
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul4_shift_add.sv
// Scoreboard bench for mul4_shift_add: random and directed products checked
// against plain a*b, plus handshake timing and reset-abort behaviour.
module tb_mul4_shift_add;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] p;

  int tests;
  int fails;

  logic [7:0] sb_q[$];
  logic [7:0] exp_p;
  logic       mon_en;
  logic       btb;
  int         n_expected;
  int         n_done;
  int         cyc;
  int         prev_done;

  mul4_shift_add dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops the expected product on every done and tracks the held value of p.
  always @(negedge clk) begin
    if (mon_en) begin
      cyc = cyc + 1;
      if (!btb) prev_done = -1;
      if (!rst_n) begin
        sb_q.delete();
        exp_p = 8'h00;
      end else begin
        if (done) begin
          n_done = n_done + 1;
          if (sb_q.size() == 0) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL unexpected_done: got done=1 with p=%h, expected no completion", p);
          end else begin
            exp_p = sb_q.pop_front();
          end
          if (btb) begin
            if (prev_done >= 0) begin
              tests = tests + 1;
              if (cyc - prev_done != 6) begin
                fails = fails + 1;
                $display("FAIL done_spacing: got %0d cycles, expected 6", cyc - prev_done);
              end
            end
            prev_done = cyc;
          end
        end
        tests = tests + 1;
        if (p !== exp_p) begin
          fails = fails + 1;
          $display("FAIL product: got p=%h, expected %h", p, exp_p);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    tests = tests + 1;
    if (got !== want) begin
      fails = fails + 1;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Issue one request and check the busy/done window; noise toggles start with other operands.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] bb, input bit noise);
    @(posedge clk); #1;
    a = ta; b = bb; start = 1'b1;
    sb_q.push_back(8'(ta) * 8'(bb));
    n_expected = n_expected + 1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("busy_window", 8'(busy), 8'(i < 5));
      chk("done_window", 8'(done), 8'(i == 4));
      if (noise && i < 5) begin
        start = ~start;
        a = 4'hF;
        b = 4'hF;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0; exp_p = 8'h00; mon_en = 1'b0; btb = 1'b0;
    n_expected = 0; n_done = 0; cyc = 0; prev_done = -1;
    rst_n = 1'b0; start = 1'b0; a = 4'h0; b = 4'h0;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_busy", 8'(busy), 8'h00);
      chk("idle_done", 8'(done), 8'h00);
      chk("idle_p", p, 8'h00);
    end

    run_op(4'd7, 4'd3, 1'b0);
    chk("p_7x3", p, 8'h15);
    run_op(4'd15, 4'd15, 1'b0);
    chk("p_15x15", p, 8'hE1);
    run_op(4'd0, 4'd9, 1'b0);
    chk("p_0x9", p, 8'h00);
    run_op(4'd9, 4'd0, 1'b0);
    chk("p_9x0", p, 8'h00);
    run_op(4'd1, 4'd15, 1'b0);
    chk("p_1x15", p, 8'h0F);

    run_op(4'd5, 4'd6, 1'b1);
    repeat (8) @(negedge clk);
    chk("p_ignored_start", p, 8'h1E);

    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(3)) @(posedge clk);
      run_op(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
    end

    // Abort: accept 12*11, then pull reset two edges later.
    @(posedge clk); #1;
    a = 4'd12; b = 4'd11; start = 1'b1;
    sb_q.push_back(8'd132);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_busy", 8'(busy), 8'h00);
      chk("abort_done", 8'(done), 8'h00);
      chk("abort_p", p, 8'h00);
    end
    run_op(4'd3, 4'd4, 1'b0);
    chk("p_3x4", p, 8'h0C);

    // Exhaustive, start held high: one acceptance every 6 edges.
    @(posedge clk); #1;
    btb = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a = 4'(i >> 4);
      b = 4'(i);
      sb_q.push_back(8'(i >> 4) * 8'(i & 15));
      n_expected = n_expected + 1;
      repeat (6) @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (10) @(negedge clk);
    btb = 1'b0;

    chk("scoreboard_empty", 8'(sb_q.size()), 8'h00);
    tests = tests + 1;
    if (n_done != n_expected) begin
      fails = fails + 1;
      $display("FAIL done_count: got %0d, expected %0d", n_done, n_expected);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
